gate_response_checker: RTL
==========================

// Module: gate_response_checker
// PURPOSE
//  Synthesizable response-side checker for 2-input gate DUTs: consumes sampled (A,B,O) vectors
//  from a stimulus driver, compares O against the truth table of the selected gate, and counts
//  vectors, mismatches and input-combination coverage. Sits beside the gate under test on-chip
//  or in a bench and gives a single pass/fail verdict per run.
// PARAMETERS
//  NUM_VEC   4     vectors per run; run ends after this many accepted samples (>=1)
//  CNT_W     8     width of vec_cnt / err_cnt (>= clog2(NUM_VEC+1))
//  WDOG      1024  idle cycles without smp_valid in CHECK before timeout (0 = disabled)
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      asynchronous reset, active-high
//  start          in   1      single-cycle pulse: latch op, clear stats, begin run
//  op             in   3      gate under test: 0 AND,1 OR,2 XOR,3 NAND,4 NOR,5 XNOR,6/7 invalid
//  smp_valid      in   1      smp_a/b/o hold a settled vector this cycle
//  smp_a          in   1      DUT input A
//  smp_b          in   1      DUT input B
//  smp_o          in   1      DUT output O
//  busy           out  1      high in CHECK
//  done           out  1      high in DONE
//  pass           out  1      valid while done: err_cnt==0 && cov==4'hF && op valid && !timeout
//  timeout        out  1      run ended by watchdog
//  vec_cnt        out  CNT_W  accepted vectors this run
//  err_cnt        out  CNT_W  mismatching vectors this run (saturating)
//  cov            out  4      bit {a,b} set once combination seen
//  first_err      out  3      {a,b,o} of first mismatch
//  first_err_vld  out  1      first_err holds a captured mismatch
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; all outputs 0.
//  - States: IDLE, CHECK, DONE.
//    IDLE -start-> CHECK. CHECK -NUM_VEC-th sample accepted-> DONE. CHECK -watchdog-> DONE.
//    DONE -start-> CHECK. start in CHECK restarts run (clear + relatch op), stays CHECK.
//  - On start edge: op latched to op_q; vec_cnt, err_cnt, cov, first_err, first_err_vld, timeout,
//    pass, watchdog counter cleared. A smp_valid coincident with start is ignored.
//  - Sample accepted only when state==CHECK && smp_valid && !start. Per accepted sample:
//    vec_cnt+1; cov[{a,b}]<=1; exp=f(op_q,a,b); if smp_o!=exp: err_cnt+1 (saturate at
//    2^CNT_W-1), and if !first_err_vld capture first_err, set first_err_vld.
//  - Invalid op_q (6/7): every accepted sample counts as a mismatch; pass forced 0.
//  - Latency: counters/cov reflect a sample 1 cycle after its accepting edge. DONE entered on the
//    edge accepting sample NUM_VEC, so done=1 and final stats visible the same next cycle.
//  - pass registered on entry to DONE from the updated stats; held until next start or rst.
//  - Watchdog: counts CHECK cycles without an accepted sample, clears on each accepted sample;
//    reaching WDOG sets timeout=1, enters DONE, pass=0. WDOG=0 disables.
//  - smp_* in IDLE/DONE ignored; stats hold in DONE until next start.
//  - vec_cnt never exceeds NUM_VEC; samples after the final one (now in DONE) ignored.
// TESTING
//  1 op=1(OR), NUM_VEC=4, vectors {a,b,o}=000,101,111,011 -> done, pass=1, err_cnt=0, cov=F, vec_cnt=4.
//  2 op=1, vectors 000,100(bad),111,011 -> err_cnt=1, first_err=3'b100, first_err_vld=1, pass=0.
//  3 op=0(AND), all four correct vectors but 00 repeated instead of 11 -> cov=4'b0111, pass=0.
//  4 start then no smp_valid for WDOG=16 cycles -> timeout=1, done=1, pass=0, vec_cnt=0.
//  5 rst asserted mid-run after 2 samples -> outputs 0 immediately (async), state IDLE; start ->
//    fresh run with vec_cnt from 0; start pulsed in CHECK after 3 samples -> stats cleared, op relatched.
//  6 op=6, four vectors -> err_cnt=4, pass=0; smp_valid together with start -> sample not counted.

Source files
------------

// File: rtl/gate_response_checker.sv
// Response-side checker for 2-input gate DUTs.
// Compares sampled (a,b,o) against the selected gate, tracks errors and coverage.
module gate_response_checker #(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8,
  parameter int WDOG    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             smp_valid,
  input  logic             smp_a,
  input  logic             smp_b,
  input  logic             smp_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [2:0]       first_err,
  output logic             first_err_vld
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  localparam int WD_W = (WDOG > 1) ? $clog2(WDOG) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((WDOG > 0) ? WDOG - 1 : 0);
  localparam logic [CNT_W-1:0] VEC_LAST =
    CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_t          state;
  logic [2:0]      op_q;
  logic [WD_W-1:0] wd;

  logic             acc;
  logic             op_ok;
  logic             exp_o;
  logic             mism;
  logic             last;
  logic             wd_exp;
  logic [CNT_W-1:0] err_nxt;
  logic [3:0]       cov_nxt;

  always_comb begin
    exp_o = 1'b0;
    op_ok = 1'b1;
    case (op_q)
      3'd0:    exp_o = smp_a & smp_b;
      3'd1:    exp_o = smp_a | smp_b;
      3'd2:    exp_o = smp_a ^ smp_b;
      3'd3:    exp_o = ~(smp_a & smp_b);
      3'd4:    exp_o = ~(smp_a | smp_b);
      3'd5:    exp_o = ~(smp_a ^ smp_b);
      default: op_ok = 1'b0;
    endcase
  end

  // Invalid gate selections make every accepted sample a mismatch.
  assign acc  = (state == CHECK) && smp_valid && !start;
  assign mism = !op_ok || (smp_o != exp_o);
  assign last = (vec_cnt == VEC_LAST);

  assign err_nxt = (mism && err_cnt != ERR_MAX)
                 ? err_cnt + 1'b1 : err_cnt;
  assign cov_nxt = cov | (4'b0001 << {smp_a, smp_b});

  assign wd_exp = (WDOG != 0) && (state == CHECK)
               && !acc && (wd == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      wd            <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      cov           <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
    end else if (start) begin
      state         <= CHECK;
      op_q          <= op;
      wd            <= '0;
      busy          <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      cov           <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
    end else begin
      case (state)
        CHECK: begin
          if (acc) begin
            wd      <= '0;
            vec_cnt <= vec_cnt + 1'b1;
            err_cnt <= err_nxt;
            cov     <= cov_nxt;
            if (mism && !first_err_vld) begin
              first_err     <= {smp_a, smp_b, smp_o};
              first_err_vld <= 1'b1;
            end
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == '0) && (cov_nxt == 4'hF)
                    && op_ok;
            end
          end else if (wd_exp) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end else if (WDOG != 0) begin
            wd <= wd + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
